// File: rtl/hazard_pkg.sv
// Shared constants and types for the register hazard scoreboard.
package hazard_pkg;
    localparam int REG_W = 5;   // register index width
    localparam int LAT_W = 3;   // latency countdown width

    typedef logic [REG_W-1:0] reg_idx_t;
    typedef logic [LAT_W-1:0] lat_t;
endpackage

// File: rtl/hazard_sb_if.sv
// ID/WB/kill bundle between the core pipeline and the hazard scoreboard.
// master = pipeline side, slave = scoreboard side.
interface hazard_sb_if #(
    parameter int REG_W = hazard_pkg::REG_W,
    parameter int LAT_W = hazard_pkg::LAT_W
);
    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_rs_used;
    logic             id_rt_used;
    logic             id_we;
    logic [REG_W-1:0] id_wreg;
    logic [LAT_W-1:0] id_lat;
    logic             wb_we;
    logic [REG_W-1:0] wb_wreg;
    logic             kill_we;
    logic [REG_W-1:0] kill_wreg;
    logic             issue_ok;
    logic             stall;
    logic [REG_W:0]   pend_cnt;
    logic             busy_any;

    modport master (
        output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_we, id_wreg, id_lat,
               wb_we, wb_wreg, kill_we, kill_wreg,
        input  issue_ok, stall, pend_cnt, busy_any
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_we, id_wreg, id_lat,
               wb_we, wb_wreg, kill_we, kill_wreg,
        output issue_ok, stall, pend_cnt, busy_any
    );
endinterface

// File: rtl/hazard_sb_entry.sv
// sb_entry: pending bit (and, with HAZARD_SB_FWD_EN, latency countdown)
// for a single architectural register.
module sb_entry #(
    parameter int LAT_W = hazard_pkg::LAT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set,
`ifdef HAZARD_SB_FWD_EN
    input  logic [LAT_W-1:0] lat,
`endif
    input  logic             clr,
    output logic             pend,
    output logic             pend_nxt,
    output logic             src_busy
);
    import hazard_pkg::*;

    // Next pending value: a new issue outranks a same-cycle writeback/kill.
    always_comb begin
        pend_nxt = set | (pend & ~clr);
    end

    // Pending bit register.
    always_ff @(posedge clk) begin
        if (!rst) pend <= 1'b0;
        else      pend <= pend_nxt;
    end

`ifdef HAZARD_SB_FWD_EN
    logic [LAT_W-1:0] cnt;

    // Countdown to forwardability: load on issue, otherwise decrement to 0.
    always_ff @(posedge clk) begin
        if (!rst)             cnt <= '0;
        else if (set)         cnt <= lat;
        else if (cnt != '0)   cnt <= cnt - 1'b1;
    end

    // Readers only wait while the result is not yet on the bypass network.
    assign src_busy = pend & (cnt != '0);
`else
    // Without forwarding, readers wait until the writeback.
    assign src_busy = pend;
`endif
endmodule

// File: rtl/hazard_sb.sv
// hazard_sb: per-register scoreboard that holds ID on RAW/WAW hazards.
// Optional feature macro: HAZARD_SB_FWD_EN (latency-aware source checks).
module hazard_sb #(
    parameter int REG_W = hazard_pkg::REG_W,
    parameter int LAT_W = hazard_pkg::LAT_W
) (
    input  logic       clk,
    input  logic       rst,
    hazard_sb_if.slave bus
);
    import hazard_pkg::*;

    localparam int NREG = 1 << REG_W;

    // Bit 0 is tied off: register 0 is never tracked.
    logic [NREG-1:0] pend;
    logic [NREG-1:0] pend_nxt;
    logic [NREG-1:0] src_busy;
    logic            rs_haz, rt_haz, wd_haz, accept;
    logic [REG_W:0]  cnt_nxt;

    assign pend[0]     = 1'b0;
    assign pend_nxt[0] = 1'b0;
    assign src_busy[0] = 1'b0;

    // Hazards are judged on the pre-edge state only.
    assign rs_haz = bus.id_rs_used & (bus.id_rs != '0) & src_busy[bus.id_rs];
    assign rt_haz = bus.id_rt_used & (bus.id_rt != '0) & src_busy[bus.id_rt];
    assign wd_haz = bus.id_we & (bus.id_wreg != '0) & pend[bus.id_wreg];

    assign bus.issue_ok = ~(rs_haz | rt_haz | wd_haz);
    assign bus.stall    = bus.id_valid & ~bus.issue_ok;
    assign accept       = bus.id_valid & bus.issue_ok;

    for (genvar r = 1; r < NREG; r++) begin : g_entry
        logic set, clr;
        assign set = accept & bus.id_we & (bus.id_wreg == REG_W'(r));
        assign clr = (bus.wb_we & (bus.wb_wreg == REG_W'(r)))
                   | (bus.kill_we & (bus.kill_wreg == REG_W'(r)));

        sb_entry #(.LAT_W(LAT_W)) u_entry (
            .clk      (clk),
            .rst      (rst),
            .set      (set),
`ifdef HAZARD_SB_FWD_EN
            .lat      (bus.id_lat),
`endif
            .clr      (clr),
            .pend     (pend[r]),
            .pend_nxt (pend_nxt[r]),
            .src_busy (src_busy[r])
        );
    end

`ifndef HAZARD_SB_FWD_EN
    // Latency is irrelevant when readers always wait for writeback.
    logic unused_lat;
    assign unused_lat = ^bus.id_lat;
`endif

    // Population count of the next pending vector.
    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < NREG; i++) begin
            cnt_nxt = cnt_nxt + (REG_W+1)'(pend_nxt[i]);
        end
    end

    // Registered pending count.
    always_ff @(posedge clk) begin
        if (!rst) bus.pend_cnt <= '0;
        else      bus.pend_cnt <= cnt_nxt;
    end

    assign bus.busy_any = (bus.pend_cnt != '0);
endmodule

// File: tb/tb_hazard_sb.sv
// Self-checking bench for hazard_sb: directed scenarios plus randomized
// traffic against a per-register array model of the scoreboard rules.
module tb_hazard_sb;
    import hazard_pkg::*;

    localparam int NREG = 1 << REG_W;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    hazard_sb_if #(.REG_W(REG_W), .LAT_W(LAT_W)) bus ();

    hazard_sb #(.REG_W(REG_W), .LAT_W(LAT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: pending flag and remaining latency per register.
    bit m_pend [NREG];
    int m_cnt  [NREG];

    function automatic bit src_haz(int s);
`ifdef HAZARD_SB_FWD_EN
        return (s != 0) && m_pend[s] && (m_cnt[s] != 0);
`else
        return (s != 0) && m_pend[s];
`endif
    endfunction

    function automatic bit model_ok();
        if (bus.id_rs_used && src_haz(int'(bus.id_rs))) return 1'b0;
        if (bus.id_rt_used && src_haz(int'(bus.id_rt))) return 1'b0;
        if (bus.id_we && bus.id_wreg != 0 && m_pend[int'(bus.id_wreg)]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int model_count();
        int n = 0;
        for (int r = 0; r < NREG; r++) n += int'(m_pend[r]);
        return n;
    endfunction

    // Advance one clock and apply the same edge to the model.
    task automatic tick();
        bit acc, rn, we, wbe, ke;
        int wr, wbr, kr, lat;
        acc = bus.id_valid && model_ok();
        rn  = rst;
        we  = bus.id_we;    wr  = int'(bus.id_wreg); lat = int'(bus.id_lat);
        wbe = bus.wb_we;    wbr = int'(bus.wb_wreg);
        ke  = bus.kill_we;  kr  = int'(bus.kill_wreg);
        @(posedge clk);
        if (!rn) begin
            for (int r = 0; r < NREG; r++) begin m_pend[r] = 1'b0; m_cnt[r] = 0; end
        end else begin
            for (int r = 1; r < NREG; r++) if (m_cnt[r] > 0) m_cnt[r]--;
            if (wbe && wbr != 0) m_pend[wbr] = 1'b0;
            if (ke && kr != 0)   m_pend[kr]  = 1'b0;
            if (acc && we && wr != 0) begin m_pend[wr] = 1'b1; m_cnt[wr] = lat; end
        end
        #1;
    endtask

    task automatic idle();
        bus.id_valid = 0; bus.id_rs = '0; bus.id_rt = '0;
        bus.id_rs_used = 0; bus.id_rt_used = 0;
        bus.id_we = 0; bus.id_wreg = '0; bus.id_lat = '0;
        bus.wb_we = 0; bus.wb_wreg = '0; bus.kill_we = 0; bus.kill_wreg = '0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
        bus.id_valid = 1; bus.id_rs = reg_idx_t'(3); bus.id_rs_used = 1;
        #1;
        checks++; if (bus.issue_ok !== 1'b1) begin failures++; $display("FAIL reset_issue_ok got=%0b exp=1", bus.issue_ok); end
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", bus.stall); end
        checks++; if (bus.pend_cnt !== '0) begin failures++; $display("FAIL reset_pend_cnt got=%0d exp=0", bus.pend_cnt); end
        checks++; if (bus.busy_any !== 1'b0) begin failures++; $display("FAIL reset_busy_any got=%0b exp=0", bus.busy_any); end
        tick();
        idle();
    endtask

`ifdef HAZARD_SB_FWD_EN
    task automatic test_load_use();
        idle();
        bus.id_valid = 1; bus.id_we = 1; bus.id_wreg = reg_idx_t'(5); bus.id_lat = lat_t'(1);
        #1;
        checks++; if (bus.issue_ok !== 1'b1) begin failures++; $display("FAIL lu_write_ok got=%0b exp=1", bus.issue_ok); end
        tick();
        idle();
        bus.id_valid = 1; bus.id_rs = reg_idx_t'(5); bus.id_rs_used = 1;
        #1;
        checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL lu_stall1 got=%0b exp=1", bus.stall); end
        tick();
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL lu_stall2 got=%0b exp=0", bus.stall); end
        checks++; if (bus.pend_cnt !== (REG_W+1)'(1)) begin failures++; $display("FAIL lu_pend_cnt got=%0d exp=1", bus.pend_cnt); end
        tick();
        idle();
        bus.wb_we = 1; bus.wb_wreg = reg_idx_t'(5);
        tick();
        idle();
        #1;
        checks++; if (bus.pend_cnt !== '0) begin failures++; $display("FAIL lu_wb_clear got=%0d exp=0", bus.pend_cnt); end
    endtask
`else
    task automatic test_load_use();
        idle();
        bus.id_valid = 1; bus.id_we = 1; bus.id_wreg = reg_idx_t'(5); bus.id_lat = lat_t'(0);
        tick();
        idle();
        bus.id_valid = 1; bus.id_rs = reg_idx_t'(5); bus.id_rs_used = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL nf_wait%0d got=%0b exp=1", i, bus.stall); end
            tick();
        end
        bus.wb_we = 1; bus.wb_wreg = reg_idx_t'(5);
        #1;
        checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL nf_wb_cycle got=%0b exp=1", bus.stall); end
        tick();
        bus.wb_we = 0;
        #1;
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL nf_after_wb got=%0b exp=0", bus.stall); end
        checks++; if (bus.pend_cnt !== '0) begin failures++; $display("FAIL nf_pend_cnt got=%0d exp=0", bus.pend_cnt); end
        tick();
        idle();
    endtask
`endif

    task automatic test_waw();
        idle();
        bus.id_valid = 1; bus.id_we = 1; bus.id_wreg = reg_idx_t'(7); bus.id_lat = lat_t'(2);
        tick();
        bus.wb_we = 1; bus.wb_wreg = reg_idx_t'(7);
        #1;
        checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL waw_same_cycle got=%0b exp=1", bus.stall); end
        tick();
        bus.wb_we = 0;
        #1;
        checks++; if (bus.issue_ok !== 1'b1) begin failures++; $display("FAIL waw_accept got=%0b exp=1", bus.issue_ok); end
        tick();
        #1;
        checks++; if (bus.pend_cnt !== (REG_W+1)'(1)) begin failures++; $display("FAIL waw_pend_cnt got=%0d exp=1", bus.pend_cnt); end
        // r7 must be pending again: another writer to r7 is held
        checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL waw_repend got=%0b exp=1", bus.stall); end
        idle();
        bus.wb_we = 1; bus.wb_wreg = reg_idx_t'(7);
        tick();
        idle();
    endtask

    task automatic test_r0();
        for (int i = 0; i < 4; i++) begin
            bus.id_valid = 1; bus.id_we = 1; bus.id_wreg = '0;
            bus.id_rs = '0; bus.id_rt = '0; bus.id_rs_used = 1; bus.id_rt_used = 1;
            bus.id_lat = lat_t'($urandom_range(0, 3));
            #1;
            checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL r0_stall%0d got=%0b exp=0", i, bus.stall); end
            checks++; if (bus.pend_cnt !== '0) begin failures++; $display("FAIL r0_pend_cnt%0d got=%0d exp=0", i, bus.pend_cnt); end
            tick();
        end
        idle();
    endtask

    task automatic test_kill_reset();
        idle();
        bus.id_valid = 1; bus.id_we = 1; bus.id_lat = lat_t'(3);
        bus.id_wreg = reg_idx_t'(9);  tick();
        bus.id_wreg = reg_idx_t'(10); tick();
        idle();
        #1;
        checks++; if (bus.pend_cnt !== (REG_W+1)'(2)) begin failures++; $display("FAIL kill_before got=%0d exp=2", bus.pend_cnt); end
        bus.kill_we = 1; bus.kill_wreg = reg_idx_t'(9);
        tick();
        idle();
        checks++; if (bus.pend_cnt !== (REG_W+1)'(1)) begin failures++; $display("FAIL kill_after got=%0d exp=1", bus.pend_cnt); end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        bus.id_valid = 1; bus.id_rs = reg_idx_t'(10); bus.id_rs_used = 1;
        #1;
        checks++; if (bus.pend_cnt !== '0) begin failures++; $display("FAIL midrst_pend_cnt got=%0d exp=0", bus.pend_cnt); end
        checks++; if (bus.issue_ok !== 1'b1) begin failures++; $display("FAIL midrst_reader got=%0b exp=1", bus.issue_ok); end
        tick();
        idle();
        bus.wb_we = 1; bus.wb_wreg = reg_idx_t'(10);  // stale writeback, harmless
        tick();
        idle();
        #1;
        checks++; if (bus.busy_any !== 1'b0) begin failures++; $display("FAIL stale_wb_busy got=%0b exp=0", bus.busy_any); end
    endtask

    task automatic test_random();
        bit exp_ok;
        int exp_n;
        for (int i = 0; i < 600; i++) begin
            rst            = ($urandom_range(0, 79) != 0);
            bus.id_valid   = ($urandom_range(0, 3) != 0);
            bus.id_rs      = reg_idx_t'($urandom_range(0, 7));
            bus.id_rt      = reg_idx_t'($urandom_range(0, 7));
            bus.id_rs_used = $urandom_range(0, 1);
            bus.id_rt_used = $urandom_range(0, 1);
            bus.id_we      = $urandom_range(0, 1);
            bus.id_wreg    = reg_idx_t'($urandom_range(0, 7));
            bus.id_lat     = lat_t'($urandom_range(0, 3));
            bus.wb_we      = ($urandom_range(0, 2) == 0);
            bus.wb_wreg    = reg_idx_t'($urandom_range(0, 7));
            bus.kill_we    = ($urandom_range(0, 7) == 0);
            bus.kill_wreg  = reg_idx_t'($urandom_range(0, 7));
            #1;
            exp_ok = model_ok();
            exp_n  = model_count();
            checks++; if (bus.issue_ok !== exp_ok) begin failures++; $display("FAIL rnd_issue_ok cyc=%0d got=%0b exp=%0b", i, bus.issue_ok, exp_ok); end
            checks++; if (bus.stall !== (bus.id_valid & ~exp_ok)) begin failures++; $display("FAIL rnd_stall cyc=%0d got=%0b exp=%0b", i, bus.stall, bus.id_valid & ~exp_ok); end
            checks++; if (bus.pend_cnt !== (REG_W+1)'(exp_n)) begin failures++; $display("FAIL rnd_pend_cnt cyc=%0d got=%0d exp=%0d", i, bus.pend_cnt, exp_n); end
            checks++; if (bus.busy_any !== (exp_n != 0)) begin failures++; $display("FAIL rnd_busy_any cyc=%0d got=%0b exp=%0b", i, bus.busy_any, exp_n != 0); end
            tick();
        end
        rst = 1'b1;
        idle();
    endtask

    initial begin
        idle();
        #1;
        test_reset();
        test_load_use();
        test_waw();
        test_r0();
        test_kill_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hazard_sb.md
# hazard_sb

Parametrised register scoreboard for the pipelined core. It tracks every in-flight register write and holds the ID stage while a source or destination register is not yet safe to use. It replaces ad-hoc load-use handling with per-register pending bits and latency countdowns. It sits beside the ID stage: the control decode and register read feed it, and its `stall` output freezes the PC and IF/ID and bubbles ID/EX.

## Interface
Parameters:
- `REG_W`, 5: register index width; the design holds 2^REG_W registers. Register 0 is never tracked.
- `LAT_W`, 3: width of the per-register latency countdown.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: synchronous, active-low reset.
- `id_valid`, in, 1: an instruction is present in ID.
- `id_rs`, in, REG_W: first source register index.
- `id_rt`, in, REG_W: second source register index.
- `id_rs_used`, in, 1: the instruction reads `id_rs`.
- `id_rt_used`, in, 1: the instruction reads `id_rt`.
- `id_we`, in, 1: the instruction writes a register.
- `id_wreg`, in, REG_W: destination register index.
- `id_lat`, in, LAT_W: cycles after issue until the result is forwardable. For the current core: 0 for ALU ops, 1 for loads.
- `wb_we`, in, 1: the WB stage is writing the register file this cycle.
- `wb_wreg`, in, REG_W: WB destination register.
- `kill_we`, in, 1: a squashed in-flight instruction had a destination.
- `kill_wreg`, in, REG_W: destination of the squashed instruction.
- `issue_ok`, out, 1: the ID instruction may advance (combinational).
- `stall`, out, 1: equals `id_valid & ~issue_ok`.
- `pend_cnt`, out, REG_W+1: number of registers currently pending (registered).
- `busy_any`, out, 1: equals `pend_cnt != 0`.

## Operation
- State per register r (r ≠ 0): `pend[r]` and `cnt[r]` (LAT_W bits).
- Source hazard: a used source s with s ≠ 0 and `pend[s]` set, qualified by the mode in Configuration.
- Destination hazard (WAW): `id_we`, `id_wreg` ≠ 0 and `pend[id_wreg]` set.
- `issue_ok` = no source hazard and no destination hazard. Index 0 never causes a hazard.
- Accept: `id_valid & issue_ok`.
  - On accept with `id_we` and `id_wreg` ≠ 0, set `pend[id_wreg]` and load `cnt[id_wreg]` = `id_lat`.
- Every cycle, each nonzero `cnt` decrements by 1 and saturates at 0.
- `wb_we` with `wb_wreg` ≠ 0 clears `pend[wb_wreg]`. A kill clears `pend[kill_wreg]` the same way.
- Priority on one register in the same cycle: accept-set beats writeback-clear and kill-clear.
- Hazard evaluation always uses the state before the clock edge. A same-cycle writeback or kill does not make a register ready until the next cycle.
- `pend_cnt` is updated with the net change each cycle, i.e. the population count of the new `pend` vector. It never exceeds 2^REG_W − 1.

## Timing
- Reset (`rst` = 0 at a clock edge): all `pend` = 0, all `cnt` = 0, `pend_cnt` = 0, `busy_any` = 0. Directly after reset, `issue_ok` = 1 and `stall` = 0.
- `issue_ok` and `stall` are combinational, with zero latency from the ID inputs and current state. All state changes occur on the rising edge of `clk`.
- Reset asserted mid-operation discards all pending state at that edge; any in-flight writebacks afterwards find clear entries, which is harmless.
- A source that is pending with `cnt` = k (FWD_EN built) stalls for exactly k cycles.

## Configuration
- Macro `HAZARD_SB_FWD_EN`.
- Defined: a source hazard exists only while `pend[s]` is set and `cnt[s]` ≠ 0. The forwarding network covers the rest, so an ALU result (`id_lat` = 0) is usable by the next instruction with no stall, and a load dependant stalls 1 cycle.
- Undefined: a source hazard exists while `pend[s]` is set, i.e. until the writeback of that register. The countdown registers and their logic are not built. The destination rule is the same in both builds.

## Structure
- Shared package `hazard_pkg`:
  - default constants `REG_W` and `LAT_W`;
  - typedefs `reg_idx_t` and `lat_t`.
- One sub-module, `sb_entry`, holding a single register's `pend`/`cnt` with set/clear/decrement logic. It is instantiated 2^REG_W − 1 times by a generate loop.
- The top level holds the hazard comparators and the `pend_cnt` population count.

## Test plan
- Reset with `rst` = 0 for 2 cycles, then `id_valid` = 1 reading r3 -> `issue_ok` = 1, `pend_cnt` = 0, `busy_any` = 0.
- FWD_EN: issue a write to r5 with `id_lat` = 1, then a reader of r5 the next cycle -> `stall` = 1 for exactly 1 cycle, then accepted.
- No FWD_EN: issue a write to r5 with `id_lat` = 0, then a reader of r5 -> `stall` stays 1 until the cycle after `wb_we` with `wb_wreg` = 5.
- WAW with simultaneous events: r7 pending, `wb_wreg` = 7 in the same cycle as an ID write to r7 -> stall that cycle; the next cycle the instruction is accepted, `pend[7]` = 1 and `pend_cnt` is unchanged.
- Writes to r0, and reads of r0 while issuing writes to r0 back-to-back -> never stall, `pend_cnt` stays 0.
- Kill and reset: r9 and r10 pending, kill r9 -> `pend_cnt` goes from 2 to 1; assert reset mid-operation -> `pend_cnt` = 0 and a reader of r10 is accepted.
